// File: rtl/join_match_store_if.sv
// ============================================================================
//  Module   : join_match_store_if
//  Purpose  : Token-in / pair-out handshake bundle for join_match_store.
//             The slave modport is the match store's view, and the master
//             modport is the producer/consumer side.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface join_match_store_if #(
  parameter int TAG_W  = 18,
  parameter int DATA_W = 16
);
  // incoming operand token
  logic              in_valid;
  logic              in_ready;
  logic [TAG_W-1:0]  in_tag;
  logic              in_lr;
  logic [DATA_W-1:0] in_data;

  // fired operand pair
  logic              out_valid;
  logic              out_ready;
  logic [TAG_W-1:0]  out_tag;
  logic [DATA_W-1:0] out_data_l;
  logic [DATA_W-1:0] out_data_r;

  modport slave (
    input  in_valid, in_tag, in_lr, in_data, out_ready,
    output in_ready, out_valid, out_tag, out_data_l, out_data_r
  );

  modport master (
    output in_valid, in_tag, in_lr, in_data, out_ready,
    input  in_ready, out_valid, out_tag, out_data_l, out_data_r
  );
endinterface

`default_nettype wire

// File: rtl/join_match_store.sv
// ============================================================================
//  Module   : join_match_store
//  Purpose  : Dataflow join (matching) store. Incoming operand tokens either
//             pair with a waiting opposite-side token of the same tag and fire
//             a pair into a one-deep output register, or wait in a small
//             associative table of DEPTH entries.
//  Options  : JOIN_MATCH_STATS_EN - when defined, match_cnt counts fired pairs
//             (16-bit, wrapping); when undefined, match_cnt is constant 0.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module join_match_store #(
  parameter int TAG_W  = 18,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  wire                          cp,
  input  wire                          mr_n,
  join_match_store_if.slave            bus,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic [15:0]                  match_cnt
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  // waiting-operand table; only the valid bits carry reset
  logic [DEPTH-1:0]  ent_valid;
  logic [TAG_W-1:0]  ent_tag  [DEPTH];
  logic              ent_lr   [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];

  logic [CNT_W-1:0]  count_q;

  // output pair register
  logic              pair_valid;
  logic [TAG_W-1:0]  pair_tag;
  logic [DATA_W-1:0] pair_l;
  logic [DATA_W-1:0] pair_r;

  // lookup results
  logic              hit;
  logic [IDX_W-1:0]  hit_idx;
  logic [IDX_W-1:0]  free_idx;

  logic              out_free;
  logic              accept;
  logic              fire;
  logic              store;

  // Associative lookup: an entry hits on equal tag with the opposite side.
  // Scanning downwards leaves the lowest hitting index selected.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_valid[i] && (ent_tag[i] == bus.in_tag) && (ent_lr[i] != bus.in_lr)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Lowest-index invalid entry receives a stored token; only used when not full.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_valid[i]) begin
        free_idx = IDX_W'(i);
      end
    end
  end

  // The output register can take a new pair if empty or being drained now.
  // A token is only accepted when it can complete: fire into a free output
  // register, or land in a free table slot (which also needs out_free so
  // that a blocked output stalls the whole input side uniformly).
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign out_free = !pair_valid || bus.out_ready;
  assign bus.in_ready = out_free && (hit || !full);
  assign accept   = bus.in_valid && bus.in_ready;
  assign fire     = accept && hit;
  assign store    = accept && !hit;

  // Valid bits: set on store into the free slot, cleared when a match consumes it.
  always_ff @(posedge cp or negedge mr_n) begin
    if (!mr_n) begin
      ent_valid <= '0;
    end else if (fire) begin
      ent_valid[hit_idx] <= 1'b0;
    end else if (store) begin
      ent_valid[free_idx] <= 1'b1;
    end
  end

  // Entry payload written on store; contents are don't-care while invalid.
  always_ff @(posedge cp) begin
    if (store) begin
      ent_tag[free_idx]  <= bus.in_tag;
      ent_lr[free_idx]   <= bus.in_lr;
      ent_data[free_idx] <= bus.in_data;
    end
  end

  // Occupancy tracks stores and matches; the two never coincide.
  always_ff @(posedge cp or negedge mr_n) begin
    if (!mr_n) begin
      count_q <= '0;
    end else if (store) begin
      count_q <= count_q + CNT_W'(1);
    end else if (fire) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  // Output pair register: load on fire (left operand is whichever side has lr=0),
  // otherwise drop the pair once the consumer takes it.
  always_ff @(posedge cp or negedge mr_n) begin
    if (!mr_n) begin
      pair_valid <= 1'b0;
      pair_tag   <= '0;
      pair_l     <= '0;
      pair_r     <= '0;
    end else if (fire) begin
      pair_valid <= 1'b1;
      pair_tag   <= bus.in_tag;
      if (bus.in_lr) begin
        pair_l <= ent_data[hit_idx];
        pair_r <= bus.in_data;
      end else begin
        pair_l <= bus.in_data;
        pair_r <= ent_data[hit_idx];
      end
    end else if (bus.out_ready) begin
      pair_valid <= 1'b0;
    end
  end

  assign bus.out_valid  = pair_valid;
  assign bus.out_tag    = pair_tag;
  assign bus.out_data_l = pair_l;
  assign bus.out_data_r = pair_r;
  assign count          = count_q;

`ifdef JOIN_MATCH_STATS_EN
  logic [15:0] fire_cnt;

  // Fired-pair statistics, wrapping at 16 bits.
  always_ff @(posedge cp or negedge mr_n) begin
    if (!mr_n) begin
      fire_cnt <= '0;
    end else if (fire) begin
      fire_cnt <= fire_cnt + 16'd1;
    end
  end

  assign match_cnt = fire_cnt;
`else
  assign match_cnt = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_join_match_store.sv
// ============================================================================
//  Module   : tb_join_match_store
//  Purpose  : Self-checking bench for join_match_store: a slot-level
//             behavioural model checked every cycle, plus directed scenarios
//             with hand-computed expectations.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_join_match_store;

  localparam int TAG_W  = 18;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH+1);

  logic             cp;
  logic             mr_n;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic [15:0]      match_cnt;

  int checks = 0;
  int errors = 0;

  join_match_store_if #(.TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

  join_match_store #(.TAG_W(TAG_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .cp        (cp),
    .mr_n      (mr_n),
    .bus       (bus),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .match_cnt (match_cnt)
  );

  initial begin
    cp = 1'b0;
    forever #5 cp = ~cp;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit                m_v    [DEPTH];
  logic [TAG_W-1:0]  m_tag  [DEPTH];
  bit                m_lr   [DEPTH];
  logic [DATA_W-1:0] m_data [DEPTH];
  bit                m_ov;
  logic [TAG_W-1:0]  m_otag;
  logic [DATA_W-1:0] m_l, m_r;
  logic [15:0]       m_match;

  function automatic int m_hit();
    for (int i = 0; i < DEPTH; i++)
      if (m_v[i] && m_tag[i] == bus.in_tag && m_lr[i] != bus.in_lr) return i;
    return -1;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += m_v[i] ? 1 : 0;
    return c;
  endfunction

  function automatic bit m_ready();
    return (!m_ov || bus.out_ready) && (m_hit() >= 0 || m_count() < DEPTH);
  endfunction

  int  mh;
  bit  mrdy;

  // Advance the model on every clock edge; reset empties it immediately.
  always @(posedge cp or negedge mr_n) begin
    if (!mr_n) begin
      for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
      m_ov = 1'b0; m_otag = '0; m_l = '0; m_r = '0; m_match = '0;
    end else begin
      mh   = m_hit();
      mrdy = m_ready();
      if (bus.in_valid && mrdy && mh >= 0) begin
        m_v[mh] = 1'b0;
        m_ov    = 1'b1;
        m_otag  = bus.in_tag;
        if (bus.in_lr) begin m_l = m_data[mh]; m_r = bus.in_data; end
        else           begin m_l = bus.in_data; m_r = m_data[mh]; end
`ifdef JOIN_MATCH_STATS_EN
        m_match = m_match + 16'd1;
`endif
      end else begin
        if (bus.in_valid && mrdy) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (!m_v[i]) begin
              m_v[i] = 1'b1; m_tag[i] = bus.in_tag; m_lr[i] = bus.in_lr; m_data[i] = bus.in_data;
              break;
            end
          end
        end
        if (m_ov && bus.out_ready) m_ov = 1'b0;
      end
    end
  end

  // Compare every DUT output against the model mid-cycle.
  always @(negedge cp) begin
    if (mr_n) begin
      chk("in_ready",   32'(bus.in_ready),   32'(m_ready()));
      chk("out_valid",  32'(bus.out_valid),  32'(m_ov));
      chk("out_tag",    32'(bus.out_tag),    32'(m_otag));
      chk("out_data_l", 32'(bus.out_data_l), 32'(m_l));
      chk("out_data_r", 32'(bus.out_data_r), 32'(m_r));
      chk("count",      32'(count),          32'(m_count()));
      chk("full",       32'(full),           32'(m_count() == DEPTH));
      chk("empty",      32'(empty),          32'(m_count() == 0));
      chk("match_cnt",  32'(match_cnt),      32'(m_match));
    end
  end

  // ---------------- directed stimulus ----------------
  // Present a token and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic send(input logic [TAG_W-1:0] t, input bit lr, input logic [DATA_W-1:0] d);
    int n = 0;
    bus.in_valid = 1'b1; bus.in_tag = t; bus.in_lr = lr; bus.in_data = d;
    @(negedge cp);
    while (!bus.in_ready && n < 50) begin
      @(negedge cp);
      n++;
    end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout got in_ready=0 want 1 tag %0h", t);
    end
    @(posedge cp);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge cp);
    #1;
  endtask

  initial begin
    mr_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_tag = '0; bus.in_lr = 1'b0; bus.in_data = '0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_count",     32'(count),         32'd0);
    chk("rst_empty",     32'(empty),         32'd1);
    chk("rst_full",      32'(full),          32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_match_cnt", 32'(match_cnt),     32'd0);
    @(negedge cp);
    mr_n = 1'b1;
    @(posedge cp); #1;

    // basic pair, left first
    send(18'h00012, 1'b0, 16'h1111);
    chk("p1_count1", 32'(count), 32'd1);
    send(18'h00012, 1'b1, 16'h2222);
    chk("p1_count0", 32'(count),          32'd0);
    chk("p1_valid",  32'(bus.out_valid),  32'd1);
    chk("p1_tag",    32'(bus.out_tag),    32'h00012);
    chk("p1_l",      32'(bus.out_data_l), 32'h1111);
    chk("p1_r",      32'(bus.out_data_r), 32'h2222);
    idle(1);

    // reversed arrival
    send(18'h00020, 1'b1, 16'hAAAA);
    send(18'h00020, 1'b0, 16'hBBBB);
    chk("rev_l", 32'(bus.out_data_l), 32'hBBBB);
    chk("rev_r", 32'(bus.out_data_r), 32'hAAAA);
    idle(1);

    // fill, block on miss, fire on hit while full
    for (int i = 1; i <= 4; i++) send(18'(i), 1'b0, 16'(16'h0100 + i));
    chk("fill_full",  32'(full),  32'd1);
    chk("fill_count", 32'(count), 32'd4);
    bus.in_valid = 1'b1; bus.in_tag = 18'd5; bus.in_lr = 1'b0; bus.in_data = 16'h0555;
    @(negedge cp);
    chk("full_miss_ready", 32'(bus.in_ready), 32'd0);
    @(posedge cp); #1;
    chk("full_miss_count", 32'(count), 32'd4);
    bus.in_valid = 1'b0;
    send(18'd3, 1'b1, 16'h3333);
    chk("full_hit_tag",   32'(bus.out_tag),    32'd3);
    chk("full_hit_l",     32'(bus.out_data_l), 32'h0103);
    chk("full_hit_count", 32'(count),          32'd3);
    send(18'd1, 1'b1, 16'h1001);
    send(18'd2, 1'b1, 16'h1002);
    send(18'd4, 1'b1, 16'h1004);
    chk("drain_empty", 32'(empty), 32'd1);
    idle(1);

    // back-pressure from a blocked output register
    bus.out_ready = 1'b0;
    send(18'h00031, 1'b0, 16'h0C0C);
    send(18'h00030, 1'b0, 16'h0A0A);
    send(18'h00030, 1'b1, 16'h0B0B);
    chk("bp_valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b1; bus.in_tag = 18'h00031; bus.in_lr = 1'b1; bus.in_data = 16'h0D0D;
    @(negedge cp);
    chk("bp_ready_blocked", 32'(bus.in_ready), 32'd0);
    @(posedge cp); #1;
    chk("bp_hold_tag", 32'(bus.out_tag),    32'h00030);
    chk("bp_hold_l",   32'(bus.out_data_l), 32'h0A0A);
    bus.out_ready = 1'b1;
    @(negedge cp);
    chk("bp_ready_free", 32'(bus.in_ready), 32'd1);
    @(posedge cp); #1;
    bus.in_valid = 1'b0;
    chk("bp_reload_valid", 32'(bus.out_valid),  32'd1);
    chk("bp_reload_tag",   32'(bus.out_tag),    32'h00031);
    chk("bp_reload_l",     32'(bus.out_data_l), 32'h0C0C);
    chk("bp_reload_r",     32'(bus.out_data_r), 32'h0D0D);
    idle(1);

    // same tag, same side stored separately; lowest entry matched first
    send(18'd7, 1'b0, 16'h0001);
    send(18'd7, 1'b0, 16'h0002);
    chk("dup_count2", 32'(count), 32'd2);
    send(18'd7, 1'b1, 16'h0003);
    chk("dup_l",      32'(bus.out_data_l), 32'h0001);
    chk("dup_r",      32'(bus.out_data_r), 32'h0003);
    chk("dup_count1", 32'(count),          32'd1);
    send(18'd7, 1'b1, 16'h0004);
    chk("dup2_l", 32'(bus.out_data_l), 32'h0002);
    idle(1);

    // back-to-back fires at one pair per cycle
    send(18'h00060, 1'b0, 16'h6000);
    send(18'h00061, 1'b0, 16'h6100);
    send(18'h00060, 1'b1, 16'h6001);
    send(18'h00061, 1'b1, 16'h6101);
    chk("b2b_tag", 32'(bus.out_tag), 32'h00061);
    idle(1);

    // asynchronous reset mid-cycle with stored entries and a pending pair
    bus.out_ready = 1'b0;
    send(18'h00040, 1'b0, 16'h4000);
    send(18'h00041, 1'b0, 16'h4100);
    send(18'h00042, 1'b0, 16'h4200);
    send(18'h00042, 1'b1, 16'h4201);
    chk("pre_rst_count", 32'(count), 32'd2);
    #2;
    mr_n = 1'b0;
    #1;
    chk("mid_rst_count",     32'(count),          32'd0);
    chk("mid_rst_out_valid", 32'(bus.out_valid),  32'd0);
    chk("mid_rst_match_cnt", 32'(match_cnt),      32'd0);
    chk("mid_rst_empty",     32'(empty),          32'd1);
    chk("mid_rst_tag",       32'(bus.out_tag),    32'd0);
    chk("mid_rst_l",         32'(bus.out_data_l), 32'd0);
    @(negedge cp);
    mr_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge cp); #1;
    for (int i = 0; i < 3; i++) begin
      send(18'(18'h00050 + i), 1'b0, 16'(16'h5000 + i));
      send(18'(18'h00050 + i), 1'b1, 16'(16'h5100 + i));
    end
`ifdef JOIN_MATCH_STATS_EN
    chk("stats_after_rst", 32'(match_cnt), 32'd3);
`else
    chk("stats_disabled", 32'(match_cnt), 32'd0);
`endif
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/join_match_store.md
JOIN_MATCH_STORE -- requirements
Module: join_match_store

Interface
REQ-001 Parameter TAG_W, default 18, width of match tag (colour/generation/destination).
REQ-002 Parameter DATA_W, default 16, operand data width.
REQ-003 Parameter DEPTH, default 4, number of waiting-operand entries, 2..16.
REQ-004 CP input 1, sole clock; all state updates on rising edge.
REQ-005 MR_N input 1, master reset, asynchronous, active-low.
REQ-006 IN_VALID input 1, incoming token present.
REQ-007 IN_READY output 1, token accepted this edge when high with IN_VALID.
REQ-008 IN_TAG input TAG_W, token match tag.
REQ-009 IN_LR input 1, operand side: 0 = left, 1 = right.
REQ-010 IN_DATA input DATA_W, operand value.
REQ-011 OUT_VALID output 1, fired pair held in output register.
REQ-012 OUT_READY input 1, downstream takes pair when high with OUT_VALID.
REQ-013 OUT_TAG output TAG_W, tag of fired pair.
REQ-014 OUT_DATA_L, OUT_DATA_R outputs DATA_W each, left and right operands of fired pair.
REQ-015 COUNT output $clog2(DEPTH+1), number of valid waiting entries.
REQ-016 FULL, EMPTY outputs 1, COUNT==DEPTH and COUNT==0.
REQ-017 MATCH_CNT output 16, fire statistics (see Configuration).

Function
REQ-018 Each entry SHALL hold valid bit, tag, LR, data.
REQ-019 Hit SHALL be combinational: some valid entry has tag==IN_TAG and LR!=IN_LR; lowest-index hitting entry is selected.
REQ-020 OUT_FREE SHALL be !OUT_VALID || OUT_READY; IN_READY SHALL equal OUT_FREE && (hit || !FULL).
REQ-021 Accepted token with hit: selected entry invalidated; output register loaded next edge with IN_TAG and operands placed by LR (stored or incoming LR=0 to OUT_DATA_L); OUT_VALID=1; latency one cycle.
REQ-022 Accepted token without hit: written into lowest-index invalid entry; no output activity.
REQ-023 Same tag and same LR as a waiting entry SHALL be no hit; token stored as separate entry.
REQ-024 OUT_VALID SHALL hold, with OUT_TAG/OUT_DATA_* stable, until OUT_READY; OUT_READY with no new fire clears OUT_VALID.
REQ-025 OUT_READY and new fire on same edge: output register reloaded, OUT_VALID stays 1; sustained throughput one pair per cycle.
REQ-026 COUNT: +1 on store, -1 on hit, unchanged otherwise; never exceeds DEPTH or wraps below 0.
REQ-027 FULL with no hit: IN_READY=0; token held upstream, no entry overwritten.
REQ-028 Output register blocked (OUT_VALID && !OUT_READY): IN_READY=0 even on hit, so no fire is lost.
REQ-029 IN_* SHALL be ignored when IN_VALID=0; OUT_READY ignored when OUT_VALID=0.

Reset
REQ-030 MR_N low SHALL immediately clear all entry valid bits, OUT_VALID, COUNT, MATCH_CNT, OUT_TAG, OUT_DATA_L, OUT_DATA_R to 0; EMPTY=1, FULL=0.
REQ-031 Reset mid-operation SHALL discard waiting operands and any undelivered pair; first accept possible on first rising edge after MR_N returns high.
REQ-032 Entry tag/data fields need no reset; only valid bits are reset.

Configuration
REQ-033 Macro JOIN_MATCH_STATS_EN defined: MATCH_CNT increments on every fire (REQ-021), wraps 16'hFFFF to 0, reset to 0.
REQ-034 Macro JOIN_MATCH_STATS_EN undefined: MATCH_CNT tied to 0, counter logic absent; all other behaviour identical.

Verification
REQ-035 Tag 0x00012 LR=0 data 0x1111, then tag 0x00012 LR=1 data 0x2222 -> COUNT 1 then 0; next cycle OUT_VALID=1, OUT_TAG=0x00012, L=0x1111, R=0x2222.
REQ-036 Reversed arrival (LR=1 data 0xAAAA first, LR=0 data 0xBBBB second) -> OUT_DATA_L=0xBBBB, OUT_DATA_R=0xAAAA.
REQ-037 DEPTH=4, four distinct tags 1..4 LR=0 -> FULL=1; tag 5 LR=0 -> IN_READY=0; tag 3 LR=1 -> IN_READY=1, fire tag 3, COUNT=3.
REQ-038 OUT_READY=0 with pending pair, matching token presented -> IN_READY=0, output unchanged; OUT_READY=1 and fire same edge -> new pair loaded, OUT_VALID stays 1.
REQ-039 Two LR=0 tokens tag 7 (0x0001, 0x0002), one LR=1 tag 7 0x0003 -> pair L=0x0001, R=0x0003; COUNT=1 remains.
REQ-040 Store two entries, pull MR_N low mid-cycle -> COUNT=0, OUT_VALID=0, MATCH_CNT=0 immediately; with JOIN_MATCH_STATS_EN, three fires after reset -> MATCH_CNT=3.
